// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the two-master RAM arbiter.
//               FSM state encoding (one-hot), RAM access size codes and the
//               master count.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BUSY = 3'b010,
    S_DONE = 3'b100
  } arb_state_e;

  // Access size codes carried on the hb field
  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b00;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_rr
// Description : Combinational two-way round-robin picker.
//               Ports:
//                 req    [1:0] in  request vector, bit n = master n
//                 last         in  index of the master granted last
//                 winner       out index of the selected master
//                 valid        out at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
  output logic                   winner,
  output logic                   valid
);

  // A lone requester always wins; on a tie the master that was not
  // served last goes first.
  assign valid  = |req;
  assign winner = (&req) ? ~last : req[1];

endmodule : ram_arb_rr
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares the single-port on-chip RAM between instruction fetch
//               (master 0) and the load/store unit (master 1) with
//               round-robin fairness and a no-grant watchdog.
//               Ports:
//                 clk_i, rst_ni            clock, synchronous active-low reset
//                 mX_req_i/addr_i/wdata_i/we_i/hb_i   master request bus
//                 mX_gnt_o / mX_err_o      completion / timeout pulse
//                 mX_rdata_o               RAM read data (broadcast)
//                 ram_ce_o/req_o/addr_o/wdata_o/we_o/hb_o  RAM request bus
//                 ram_gnt_i, ram_rdata_i   RAM grant / read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0 : instruction fetch
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_hb_i,
  output logic        m0_gnt_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  // master 1 : load/store unit
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_hb_i,
  output logic        m1_gnt_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  // RAM side
  output logic        ram_ce_o,
  output logic        ram_req_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic        ram_we_o,
  output logic [1:0]  ram_hb_o,
  input  logic        ram_gnt_i,
  input  logic [31:0] ram_rdata_i
);

  localparam int         CNT_W   = 8;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       r_state;
  logic             r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic             w_winner;
  logic             w_valid;
  logic             w_busy;
  logic             w_timeout;
  logic             w_done;

  ram_arb_rr u_rr (
    .req    ({m1_req_i, m0_req_i}),
    .last   (r_last),
    .winner (w_winner),
    .valid  (w_valid)
  );

  assign w_busy    = (r_state == S_BUSY);
  assign w_timeout = (r_cnt == C_CNT_LAST);
  // A grant on the final count takes priority over the timeout.
  assign w_done    = ram_gnt_i | w_timeout;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;   // master 0 wins the first tie
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done) begin
            r_last  <= r_owner;
            r_state <= S_DONE;
          end
        end
        // One dead cycle with the request bus low lets the RAM return
        // to its idle state before the next arbitration.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM request bus: driven from the owner's live inputs only while BUSY.
  always_comb begin
    ram_ce_o    = 1'b0;
    ram_req_o   = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_hb_o    = '0;
    if (w_busy) begin
      ram_ce_o  = 1'b1;
      ram_req_o = 1'b1;
      if (r_owner) begin
        ram_addr_o  = m1_addr_i;
        ram_wdata_o = m1_wdata_i;
        ram_we_o    = m1_we_i;
        ram_hb_o    = m1_hb_i;
      end else begin
        ram_addr_o  = m0_addr_i;
        ram_wdata_o = m0_wdata_i;
        ram_we_o    = m0_we_i;
        ram_hb_o    = m0_hb_i;
      end
    end
  end

  // Completion is forwarded in the same cycle as the RAM grant.
  assign m0_gnt_o   = w_busy & ram_gnt_i & ~r_owner;
  assign m1_gnt_o   = w_busy & ram_gnt_i &  r_owner;
  assign m0_err_o   = w_busy & ~ram_gnt_i & w_timeout & ~r_owner;
  assign m1_err_o   = w_busy & ~ram_gnt_i & w_timeout &  r_owner;

  assign m0_rdata_o = ram_rdata_i;
  assign m1_rdata_o = ram_rdata_i;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a small
//               RAM model that grants on the third request cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_hb, m1_hb;
  logic        m0_gnt, m0_err, m1_gnt, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_req, ram_we, ram_gnt;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_hb;

  always #5 clk = ~clk;

  ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_we_i(m0_we), .m0_hb_i(m0_hb), .m0_gnt_o(m0_gnt), .m0_err_o(m0_err),
    .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_we_i(m1_we), .m1_hb_i(m1_hb), .m1_gnt_o(m1_gnt), .m1_err_o(m1_err),
    .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_req_o(ram_req), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_we_o(ram_we), .ram_hb_o(ram_hb),
    .ram_gnt_i(ram_gnt), .ram_rdata_i(ram_rdata)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:63];
  logic        mem_init_done = 1'b0;
  logic [1:0]  rcnt = 2'd0;
  logic        gnt_hold = 1'b0;
  logic        gnt_force = 1'b0;

  assign ram_gnt   = (ram_req && (rcnt == 2'd2) && !gnt_hold) || gnt_force;
  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (!ram_req) rcnt <= 2'd0;
    else if (rcnt != 2'd2) rcnt <= rcnt + 2'd1;

    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h1234_5678;
      mem[4] <= 32'hDEAD_BEEF;
      mem_init_done <= 1'b1;
    end else if (ram_req && ram_gnt && ram_we) begin
      case (ram_hb)
        2'b10: mem[ram_addr[7:2]] <= ram_wdata;
        2'b01: begin
          if (ram_addr[1]) mem[ram_addr[7:2]][31:16] <= ram_wdata[15:0];
          else             mem[ram_addr[7:2]][15:0]  <= ram_wdata[15:0];
        end
        default: begin
          case (ram_addr[1:0])
            2'd0:    mem[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
            2'd1:    mem[ram_addr[7:2]][15:8]  <= ram_wdata[7:0];
            2'd2:    mem[ram_addr[7:2]][23:16] <= ram_wdata[7:0];
            default: mem[ram_addr[7:2]][31:24] <= ram_wdata[7:0];
          endcase
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic [31:0] a,
                       input logic [31:0] wd, input logic we, input logic [1:0] hb);
    if (m == 0) begin
      m0_req = req; m0_addr = a; m0_wdata = wd; m0_we = we; m0_hb = hb;
    end else begin
      m1_req = req; m1_addr = a; m1_wdata = wd; m1_we = we; m1_hb = hb;
    end
  endtask

  // Issue one request from IDLE (cycle 0) and wait for its gnt; returns the
  // gnt cycle (-1 on an expired bound) and the read data; ends in IDLE.
  task automatic xfer(input int m, input logic [31:0] a, input logic [31:0] wd,
                      input logic we, input logic [1:0] hb,
                      output int gc, output logic [31:0] rd);
    gc = -1;
    rd = '0;
    set_m(m, 1'b1, a, wd, we, hb);
    for (int c = 1; c <= 40 && gc < 0; c++) begin
      tick();
      if ((m == 0) ? m0_gnt : m1_gnt) begin
        gc = c;
        rd = (m == 0) ? m0_rdata : m1_rdata;
      end
    end
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    tick();
    tick();
  endtask

  int          gc, err_c, n_err, n_bad;
  logic [31:0] rd;
  int          who[$];
  int          cyc[$];

  initial begin
    rst_ni = 1'b0;
    set_m(0, 1'b0, 32'h0, 32'h0, 1'b0, HB_WORD);
    set_m(1, 1'b0, 32'h0, 32'h0, 1'b0, HB_WORD);

    // ---- reset state ----
    tick();
    tick();
    check_eq("rst_ram_req", 32'(ram_req), 32'd0);
    check_eq("rst_ram_ce",  32'(ram_ce), 32'd0);
    check_eq("rst_gnt_err", 32'({m0_gnt, m1_gnt, m0_err, m1_err}), 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_rdata_m0", m0_rdata, 32'h1234_5678);
    check_eq("rst_rdata_m1", m1_rdata, 32'h1234_5678);
    rst_ni = 1'b1;
    tick();

    // ---- m0 word read, cycle-by-cycle ----
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    check_eq("t1_c0_req", 32'(ram_req), 32'd0);
    tick();
    check_eq("t1_c1_req", 32'(ram_req), 32'd1);
    check_eq("t1_c1_addr", ram_addr, 32'h10);
    tick();
    check_eq("t1_c2_gnt", 32'(m0_gnt), 32'd0);
    tick();
    check_eq("t1_c3_req", 32'(ram_req), 32'd1);
    check_eq("t1_c3_gnt", 32'(m0_gnt), 32'd1);
    check_eq("t1_c3_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_eq("t1_c3_m1gnt", 32'(m1_gnt), 32'd0);
    m0_req = 1'b0;
    tick();
    check_eq("t1_c4_req", 32'(ram_req), 32'd0);
    tick();

    // ---- m1 byte write then word read ----
    xfer(1, 32'h13, 32'h0000_00A5, 1'b1, HB_BYTE, gc, rd);
    check_eq("t2_wr_lat", 32'(gc), 32'd3);
    xfer(1, 32'h10, 32'h0, 1'b0, HB_WORD, gc, rd);
    check_eq("t2_rd_lat", 32'(gc), 32'd3);
    check_eq("t2_rd_data", rd, 32'hA5AD_BEEF);

    // ---- both masters continuously from reset ----
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    set_m(1, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (m0_gnt) begin who.push_back(0); cyc.push_back(c); end
      if (m1_gnt) begin who.push_back(1); cyc.push_back(c); end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check_eq("t3_ngnt", 32'(who.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < who.size()) begin
        check_eq($sformatf("t3_who%0d", i), 32'(who[i]), 32'(i % 2));
        check_eq($sformatf("t3_cyc%0d", i), 32'(cyc[i]), 32'(3 + 5 * i));
      end
    end
    tick();
    tick();

    // ---- watchdog timeout, pending m1 wins afterwards ----
    gnt_hold = 1'b1;
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    err_c = -1;
    n_err = 0;
    n_bad = 0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) set_m(1, 1'b1, 32'h20, 32'h0, 1'b0, HB_WORD);
      if (m0_err) begin
        n_err++;
        if (err_c < 0) err_c = c;
        m0_req = 1'b0;
      end
      if (m0_gnt || m1_gnt || m1_err) n_bad++;
      if (c == 16) check_eq("t4_done_req", 32'(ram_req), 32'd0);
      if (c == 17) begin
        check_eq("t4_idle_req", 32'(ram_req), 32'd0);
        gnt_hold = 1'b0;
      end
    end
    check_eq("t4_err_cycle", 32'(err_c), 32'd15);
    check_eq("t4_err_count", 32'(n_err), 32'd1);
    check_eq("t4_no_gnt", 32'(n_bad), 32'd0);
    tick();
    check_eq("t4_m1_req", 32'(ram_req), 32'd1);
    check_eq("t4_m1_addr", ram_addr, 32'h20);
    tick();
    tick();
    check_eq("t4_m1_gnt", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    tick();
    tick();

    // ---- grant on the final count beats the timeout ----
    gnt_hold = 1'b1;
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 14) check_eq("t4b_c14_err", 32'(m0_err), 32'd0);
    end
    gnt_force = 1'b1;
    #1;
    check_eq("t4b_gnt", 32'(m0_gnt), 32'd1);
    check_eq("t4b_err", 32'(m0_err), 32'd0);
    gnt_force = 1'b0;
    m0_req = 1'b0;
    tick();
    tick();
    gnt_hold = 1'b0;

    // ---- reset during BUSY ----
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    check_eq("t5_req", 32'({ram_req, ram_ce, ram_we}), 32'd0);
    check_eq("t5_addr", ram_addr, 32'h0);
    check_eq("t5_gnt_err", 32'({m0_gnt, m1_gnt, m0_err, m1_err}), 32'd0);
    rst_ni = 1'b1;
    set_m(1, 1'b1, 32'h20, 32'h0, 1'b0, HB_WORD);
    tick();
    check_eq("t5_tie_addr", ram_addr, 32'h10);
    tick();
    tick();
    check_eq("t5_m0_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // ---- non-owner m1 activity must not reach the RAM ----
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, HB_WORD);
    for (int c = 1; c <= 3; c++) begin
      tick();
      set_m(1, 1'b1, 32'h20, 32'h1111_1111, (c % 2) == 1, HB_WORD);
      #1;
      check_eq($sformatf("t6_addr_c%0d", c), ram_addr, 32'h10);
      check_eq($sformatf("t6_we_c%0d", c), 32'({ram_we, m1_gnt}), 32'd0);
      check_eq($sformatf("t6_wdata_c%0d", c), ram_wdata, 32'h0);
      if (c == 3) check_eq("t6_m0_gnt", 32'(m0_gnt), 32'd1);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    check_eq("t6_mem_untouched", mem[8], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single-port on-chip `ram` between the instruction-fetch port (master 0) and the load/store unit (master 1). It selects one requester at a time with round-robin fairness, drives the RAM request bus from the owner, and forwards the RAM grant and read data back to that owner. A watchdog releases the RAM and flags an error if the RAM never grants. The block sits between the core's memory ports and the `ram` instance in the top level.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum BUSY cycles without `ram_gnt_i` before abort; legal range 3..255.

Ports:
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, synchronous, active-low
- `m0_req_i` / `m1_req_i`  in  1  master request; held high with fields stable until that master's gnt or err
- `m0_addr_i` / `m1_addr_i`  in  32  byte address
- `m0_wdata_i` / `m1_wdata_i`  in  32  write data
- `m0_we_i` / `m1_we_i`  in  1  write enable
- `m0_hb_i` / `m1_hb_i`  in  2  size: 2'b10 word, 2'b01 half, 2'b00 byte
- `m0_gnt_o` / `m1_gnt_o`  out  1  one-cycle completion pulse; rdata valid in this cycle
- `m0_err_o` / `m1_err_o`  out  1  one-cycle timeout pulse
- `m0_rdata_o` / `m1_rdata_o`  out  32  read data (broadcast of `ram_rdata_i`)
- `ram_ce_o`, `ram_req_o`  out  1  RAM chip enable / request
- `ram_addr_o`, `ram_wdata_o`  out  32  owner's address / write data
- `ram_we_o`  out  1; `ram_hb_o`  out  2
- `ram_gnt_i`  in  1  RAM grant; `ram_rdata_i`  in  32  RAM read data

## Operation
- FSM, one-hot: IDLE=3'b001, BUSY=3'b010, DONE=3'b100. Registers: `state`, `owner` (1 bit), `last` (1 bit, last granted master), `cnt`.
- IDLE: if any req, pick winner: only one requesting → it; both → `!last`. Latch `owner`, clear `cnt`, go BUSY. No req → stay.
- BUSY: `ram_req_o=ram_ce_o=1`; `ram_addr/wdata/we/hb` muxed combinationally from owner's live inputs. `cnt` increments each cycle.
  - `ram_gnt_i=1`: `mX_gnt_o=1` for owner same cycle (combinational), `last<=owner`, go DONE.
  - else `cnt==TIMEOUT-1`: `mX_err_o=1` for owner, `last<=owner`, go DONE.
- DONE: all `ram_*` request outputs 0 (lets RAM return to its IDLE); go IDLE unconditionally.
- Outside BUSY: `ram_req_o=ram_ce_o=ram_we_o=0`, `ram_addr_o/wdata_o/hb_o` = 0.
- `mX_rdata_o = ram_rdata_i` always; meaningful only when `mX_gnt_o`.
- Non-owner request is ignored until the next IDLE; its gnt/err stay 0.
- Owner dropping req in BUSY is a protocol violation; the arbiter still completes the RAM access and pulses gnt.
- Alignment errors are not checked here (RAM suppresses misaligned accesses; gnt still returns).

## Timing
- Reset (`rst_ni=0` at a rising edge): `state=IDLE`, `owner=0`, `last=1` (master 0 wins first tie), `cnt=0`; every output 0 except `mX_rdata_o` (follows `ram_rdata_i`). Reset mid-BUSY aborts with no gnt/err pulse.
- With `ram`: req seen at cycle 0 (IDLE) → `ram_req_o` cycles 1-3 → `ram_gnt_i` and `mX_gnt_o` at cycle 3 → DONE cycle 4 → IDLE cycle 5. Latency 3 cycles req→gnt; one transaction per 5 cycles.
- Both masters requesting continuously: grants alternate m0, m1, m0, …
- Timeout: err at BUSY cycle `TIMEOUT` (cycle `TIMEOUT` after arbitration), then DONE, IDLE.
- gnt and err are mutually exclusive; gnt wins if `ram_gnt_i` arrives on the final count.

## Structure
- Package `ram_arb_pkg`: state encodings `S_IDLE/S_BUSY/S_DONE`, size codes `HB_WORD/HB_HALF/HB_BYTE`, `NUM_MASTERS=2`.
- Sub-module `ram_arb_rr`: combinational two-way round-robin picker (`req[1:0]`, `last` → `winner`, `valid`); the FSM, counter and muxes stay in `ram_arbiter`.

## Test plan
- m0 only, read word 0x0000_0010 after preloading 0xDEADBEEF → `ram_req_o` cycles 1-3, `m0_gnt_o` at cycle 3 with `m0_rdata_o=0xDEADBEEF`, `m1_gnt_o` stays 0.
- m1 byte write 0xA5 to 0x0000_0013, then m1 word read 0x0000_0010 → reads 0xA5ADBEEF; each gnt 3 cycles after arbitration.
- Both masters request from reset continuously for 4 transactions → grant order m0, m1, m0, m1, gnts 5 cycles apart.
- RAM model with `ram_gnt_i` tied 0, `TIMEOUT=15`, m0 req → `m0_err_o` pulses at cycle 15, FSM returns IDLE at cycle 17, a pending m1 then wins.
- `rst_ni` low during BUSY cycle 2 → next edge all outputs 0, no gnt/err; after release m0 wins the first tie.
- m1 request held while m0 is owner, m1 `we_i` toggling on its inputs → `ram_*` fields track m0 only; no RAM write with m1 data occurs.
